// File: rtl/top_coprocessor.sv
// Fuzzy-logic gain coprocessor: trapezoidal fuzzification, 3x3 min-rule inference and
// weighted-average defuzzification, with an optional first-difference dT estimator.
module top_coprocessor #(
  parameter int unsigned LATENCY = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              init,
  input  logic              reg_mode,
  input  logic              dt_mode,
  input  logic signed [7:0] T_in,
  input  logic signed [7:0] dT_in,
  input  logic signed [7:0] T_neg_a, T_neg_b, T_neg_c, T_neg_d,
  input  logic signed [7:0] T_zero_a, T_zero_b, T_zero_c, T_zero_d,
  input  logic signed [7:0] T_pos_a, T_pos_b, T_pos_c, T_pos_d,
  input  logic signed [7:0] dT_neg_a, dT_neg_b, dT_neg_c, dT_neg_d,
  input  logic signed [7:0] dT_zero_a, dT_zero_b, dT_zero_c, dT_zero_d,
  input  logic signed [7:0] dT_pos_a, dT_pos_b, dT_pos_c, dT_pos_d,
  output logic              valid,
  output logic [7:0]        G_out
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;
  localparam logic [3:0] LatCnt = 4'(LATENCY);

  // Rule singletons pre-scaled to Q15 with rounding.
  localparam int unsigned Gq100 = (100 * 32767 + 50) / 100;
  localparam int unsigned Gq80  = (80 * 32767 + 50) / 100;
  localparam int unsigned Gq50  = (50 * 32767 + 50) / 100;
  localparam int unsigned Gq30  = (30 * 32767 + 50) / 100;
  localparam int unsigned Gq0   = (0 * 32767 + 50) / 100;

  // Rule index is 3*T_set + dT_set with sets ordered neg, zero, pos.
  function automatic logic [14:0] rule_gq(input int idx);
    case (idx)
      0:       rule_gq = 15'(Gq100);
      2:       rule_gq = 15'(Gq30);
      6:       rule_gq = 15'(Gq80);
      8:       rule_gq = 15'(Gq0);
      default: rule_gq = 15'(Gq50);
    endcase
  endfunction

  function automatic logic [14:0] mu_f(input logic signed [7:0] x, input logic signed [7:0] a,
                                       input logic signed [7:0] b, input logic signed [7:0] c,
                                       input logic signed [7:0] d);
    logic signed [8:0] num, den;
    logic [23:0]       q;
    num = 9'sd0;
    den = 9'sd1;
    q   = '0;
    if ((x <= a) || (x >= d)) begin
      mu_f = 15'd0;
    end else if ((x >= b) && (x <= c)) begin
      mu_f = 15'h7FFF;
    end else begin
      if (x < b) begin
        num = {x[7], x} - {a[7], a};
        den = {b[7], b} - {a[7], a};
      end else begin
        num = {d[7], d} - {x[7], x};
        den = {d[7], d} - {c[7], c};
      end
      if (den == 9'sd0) den = 9'sd1;
      q    = {num, 15'd0} / {15'd0, den};
      mu_f = (q > 24'd32767) ? 15'h7FFF : q[14:0];
    end
  endfunction

  logic [0:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              start_q, init_q;
  logic              valid_q, valid_d;
  logic [7:0]        g_q, g_d;
  logic signed [7:0] t_prev_q, t_prev_d;
  logic              first_q, first_d;
  logic              capture;

  logic signed [7:0] t_cap_q, dt_cap_q;
  logic              rm_q, zero_q;
  logic signed [7:0] thr_in [24];
  logic signed [7:0] thr_q  [24];
  logic [14:0]       mu_d   [6];
  logic [14:0]       mu_q   [6];
  logic [14:0]       sw_d, swg_d, sw_q, swg_q;

  logic signed [8:0] diff;
  logic signed [7:0] dt_est;
  logic [14:0]       w_c;
  logic [30:0]       prod_c;
  logic [19:0]       sw_acc, swg_acc;
  logic [14:0]       den_c;
  logic [29:0]       ratio_c;
  logic [36:0]       pct_c;
  logic [7:0]        pct;

  assign thr_in[0]  = T_neg_a;   assign thr_in[1]  = T_neg_b;
  assign thr_in[2]  = T_neg_c;   assign thr_in[3]  = T_neg_d;
  assign thr_in[4]  = T_zero_a;  assign thr_in[5]  = T_zero_b;
  assign thr_in[6]  = T_zero_c;  assign thr_in[7]  = T_zero_d;
  assign thr_in[8]  = T_pos_a;   assign thr_in[9]  = T_pos_b;
  assign thr_in[10] = T_pos_c;   assign thr_in[11] = T_pos_d;
  assign thr_in[12] = dT_neg_a;  assign thr_in[13] = dT_neg_b;
  assign thr_in[14] = dT_neg_c;  assign thr_in[15] = dT_neg_d;
  assign thr_in[16] = dT_zero_a; assign thr_in[17] = dT_zero_b;
  assign thr_in[18] = dT_zero_c; assign thr_in[19] = dT_zero_d;
  assign thr_in[20] = dT_pos_a;  assign thr_in[21] = dT_pos_b;
  assign thr_in[22] = dT_pos_c;  assign thr_in[23] = dT_pos_d;

  assign capture = (state_q == StIdle) && start && !start_q;

  // First difference, saturated to the signed 8-bit range on overflow.
  assign diff = {T_in[7], T_in} - {t_prev_q[7], t_prev_q};
  always_comb begin
    dt_est = diff[7:0];
    if (diff[8] != diff[7]) dt_est = diff[8] ? 8'sh80 : 8'sh7F;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    g_d      = g_q;
    t_prev_d = t_prev_q;
    first_d  = first_q;
    case (state_q)
      StIdle: begin
        if (capture) begin
          state_d  = StBusy;
          cnt_d    = LatCnt;
          t_prev_d = T_in;
          first_d  = 1'b0;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StIdle;
          valid_d = 1'b1;
          g_d     = zero_q ? 8'd0 : pct;
        end
      end
      default: state_d = StIdle;
    endcase
    // Re-arm wins over a same-cycle capture so the request applies to the next start.
    if (init && !init_q) first_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      init_q   <= 1'b0;
      valid_q  <= 1'b0;
      g_q      <= '0;
      t_prev_q <= '0;
      first_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      start_q  <= start;
      init_q   <= init;
      valid_q  <= valid_d;
      g_q      <= g_d;
      t_prev_q <= t_prev_d;
      first_q  <= first_d;
    end
  end

  // Stage 1: memberships of the captured operands.
  always_comb begin
    for (int s = 0; s < 6; s++) begin
      mu_d[s] = mu_f((s < 3) ? t_cap_q : dt_cap_q, thr_q[4*s], thr_q[4*s+1], thr_q[4*s+2],
                     thr_q[4*s+3]);
    end
  end

  // Stage 2: rule firing strengths and weighted sums.
  always_comb begin
    sw_acc  = '0;
    swg_acc = '0;
    w_c     = '0;
    prod_c  = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w_c    = (mu_q[i] < mu_q[3+j]) ? mu_q[i] : mu_q[3+j];
        prod_c = (31'(w_c) * 31'(rule_gq(3 * i + j)) + 31'd16384) >> 15;
        if (rm_q || ((i != 1) && (j != 1))) begin
          sw_acc  = sw_acc + 20'(w_c);
          swg_acc = swg_acc + 20'(prod_c);
        end
      end
    end
    sw_d  = (sw_acc > 20'd32767) ? 15'h7FFF : sw_acc[14:0];
    swg_d = (swg_acc > 20'd32767) ? 15'h7FFF : swg_acc[14:0];
  end

  // Stage 3: defuzzified percentage, registered into G_out at the final count.
  always_comb begin
    den_c   = (sw_q == 15'd0) ? 15'd1 : sw_q;
    ratio_c = {swg_q, 15'd0} / {15'd0, den_c};
    pct_c   = ({7'd0, ratio_c} * 37'd100) >> 15;
    pct     = (pct_c > 37'd100) ? 8'd100 : pct_c[7:0];
    if (sw_q == 15'd0) pct = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      t_cap_q  <= T_in;
      dt_cap_q <= dt_mode ? dt_est : dT_in;
      rm_q     <= reg_mode;
      zero_q   <= dt_mode & first_q;
      for (int k = 0; k < 24; k++) thr_q[k] <= thr_in[k];
    end
    if (state_q == StBusy) begin
      for (int s = 0; s < 6; s++) mu_q[s] <= mu_d[s];
      sw_q  <= sw_d;
      swg_q <= swg_d;
    end
  end

  assign valid = valid_q;
  assign G_out = g_q;

endmodule

// File: tb/tb_top_coprocessor.sv
// Bench for top_coprocessor: vector table, grid and random runs against a plain-arithmetic model.
module tb_top_coprocessor;

  localparam int LAT = 6;

  logic              clk = 1'b0;
  logic              rst_n, start, init, reg_mode, dt_mode;
  logic signed [7:0] t_in, dt_in;
  logic signed [7:0] th [24];
  logic              valid;
  logic [7:0]        g_out;

  int n_chk = 0;
  int n_pass = 0;
  int m_prev;
  bit m_first;

  always #5 clk = ~clk;

  top_coprocessor #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init(init), .reg_mode(reg_mode),
    .dt_mode(dt_mode), .T_in(t_in), .dT_in(dt_in),
    .T_neg_a(th[0]), .T_neg_b(th[1]), .T_neg_c(th[2]), .T_neg_d(th[3]),
    .T_zero_a(th[4]), .T_zero_b(th[5]), .T_zero_c(th[6]), .T_zero_d(th[7]),
    .T_pos_a(th[8]), .T_pos_b(th[9]), .T_pos_c(th[10]), .T_pos_d(th[11]),
    .dT_neg_a(th[12]), .dT_neg_b(th[13]), .dT_neg_c(th[14]), .dT_neg_d(th[15]),
    .dT_zero_a(th[16]), .dT_zero_b(th[17]), .dT_zero_c(th[18]), .dT_zero_d(th[19]),
    .dT_pos_a(th[20]), .dT_pos_b(th[21]), .dT_pos_c(th[22]), .dT_pos_d(th[23]),
    .valid(valid), .G_out(g_out)
  );

  typedef struct {
    int t;
    int dt;
    bit rm;
    int want;
    int tol;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, want);
  endtask

  task automatic set_mf(input int idx, input int a, input int b, input int c, input int d);
    th[4*idx]   = 8'(a);
    th[4*idx+1] = 8'(b);
    th[4*idx+2] = 8'(c);
    th[4*idx+3] = 8'(d);
  endtask

  task automatic default_mf();
    set_mf(0, -128, -64, -32, 0);
    set_mf(1, -16, 0, 0, 16);
    set_mf(2, 0, 32, 64, 127);
    set_mf(3, -100, -50, -30, -5);
    set_mf(4, -10, 0, 0, 10);
    set_mf(5, 5, 25, 35, 60);
  endtask

  function automatic int mu_ref(input int x, input int a, input int b, input int c, input int d);
    int r;
    if (x <= a || x >= d) return 0;
    if (x >= b && x <= c) return 32767;
    if (x < b) r = ((x - a) * 32768) / ((b == a) ? 1 : (b - a));
    else r = ((d - x) * 32768) / ((d == c) ? 1 : (d - c));
    return (r > 32767) ? 32767 : r;
  endfunction

  function automatic int model(input int t, input int dt, input bit rm);
    int     gpct [9];
    int     mt [3];
    int     md [3];
    longint sw, swg, w, gq, ratio, pct;
    gpct = '{100, 50, 30, 50, 50, 50, 80, 50, 0};
    for (int s = 0; s < 3; s++) begin
      mt[s] = mu_ref(t, th[4*s], th[4*s+1], th[4*s+2], th[4*s+3]);
      md[s] = mu_ref(dt, th[12+4*s], th[13+4*s], th[14+4*s], th[15+4*s]);
    end
    sw = 0;
    swg = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (rm || (i != 1 && j != 1)) begin
          w = (mt[i] < md[j]) ? mt[i] : md[j];
          gq = (gpct[3*i+j] * 32767 + 50) / 100;
          sw += w;
          swg += (w * gq + 16384) / 32768;
        end
      end
    end
    if (sw == 0) return 0;
    if (sw > 32767) sw = 32767;
    if (swg > 32767) swg = 32767;
    ratio = (swg * 32768) / sw;
    pct = (ratio * 100) / 32768;
    return int'((pct > 100) ? 100 : pct);
  endfunction

  // poke: 0 none, 1 second start edge while busy, 2 init pulse while busy
  task automatic run(input int t, input int dt, input bit rm, input bit dm, input int want,
                     input string name, input int poke, output int got);
    int cyc;
    bit seen;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    t_in = 8'(t);
    dt_in = 8'(dt);
    reg_mode = rm;
    dt_mode = dm;
    start = 1'b1;
    @(posedge clk);
    #1;
    t_in = 8'($urandom);
    dt_in = 8'($urandom);
    reg_mode = ~rm;
    dt_mode = ~dm;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 12) begin
      @(posedge clk);
      #1;
      cyc++;
      if (poke == 1 && cyc == 2) start = 1'b0;
      if (poke == 1 && cyc == 3) start = 1'b1;
      if (poke == 2 && cyc == 2) init = 1'b1;
      if (poke == 2 && cyc == 3) init = 1'b0;
      seen = valid;
    end
    got = seen ? int'(g_out) : -1;
    chk({name, " latency"}, seen ? cyc : -1, LAT);
    chk({name, " G_out"}, got, want);
    @(posedge clk);
    #1;
    chk({name, " valid width"}, int'(valid), 0);
    chk({name, " G_out hold"}, int'(g_out), want);
  endtask

  task automatic go(input int t, input int dt, input bit rm, input bit dm, input string name,
                    input int poke, output int got, output int want);
    int d;
    d = t - m_prev;
    if (d > 127) d = 127;
    if (d < -128) d = -128;
    if (dm) want = m_first ? 0 : model(t, d, rm);
    else want = model(t, dt, rm);
    m_prev = t;
    m_first = 1'b0;
    run(t, dt, rm, dm, want, name, poke, got);
    if (poke == 2) m_first = 1'b1;
  endtask

  task automatic init_pulse();
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    m_first = 1'b1;
  endtask

  int t_grid [10] = '{-128, -64, -32, -16, 0, 16, 32, 64, 96, 127};
  int d_grid [7] = '{-60, -30, -10, 0, 10, 30, 60};

  initial begin
    int got, want, err_sum, t, n_extra;
    rst_n = 1'b0;
    start = 1'b0;
    init = 1'b0;
    reg_mode = 1'b0;
    dt_mode = 1'b0;
    t_in = '0;
    dt_in = '0;
    m_prev = 0;
    m_first = 1'b1;
    default_mf();
    vecs[0] = '{-128, 127, 1'b1, 0, 0};
    vecs[1] = '{-64, -60, 1'b0, 100, 1};
    vecs[2] = '{64, 60, 1'b0, 0, 0};
    vecs[3] = '{-32, -30, 1'b1, 99, 0};
    vecs[4] = '{0, 0, 1'b1, 50, 0};
    vecs[5] = '{0, 0, 1'b0, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", int'(valid), 0);
    chk("reset G_out", int'(g_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      go(vecs[i].t, vecs[i].dt, vecs[i].rm, 1'b0, $sformatf("vec%0d", i), 0, got, want);
      chk($sformatf("vec%0d table |err|<=tol", i),
          int'((got - vecs[i].want <= vecs[i].tol) && (vecs[i].want - got <= vecs[i].tol)), 1);
    end

    foreach (t_grid[i]) begin
      foreach (d_grid[j]) begin
        for (int rm = 0; rm < 2; rm++) begin
          go(t_grid[i], d_grid[j], rm[0], 1'b0,
             $sformatf("grid T=%0d dT=%0d rm=%0d", t_grid[i], d_grid[j], rm), 0, got, want);
        end
      end
    end

    err_sum = 0;
    for (int n = 0; n < 1000; n++) begin
      go(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
         1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", n), 0, got, want);
      err_sum += (got > want) ? got - want : want - got;
    end
    chk("random mean abs error x1000 within 1000", int'(err_sum <= 1000), 1);

    set_mf(1, -20, -8, 8, 20);
    set_mf(5, 0, 20, 40, 80);
    for (int n = 0; n < 50; n++) begin
      go(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
         1'($urandom_range(0, 1)), 1'b0, $sformatf("mf2 rand%0d", n), 0, got, want);
    end
    default_mf();

    go(16, 10, 1'b1, 1'b0, "busy restart", 1, got, want);
    n_extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (valid) n_extra++;
    end
    chk("busy restart extra valids", n_extra, 0);

    init_pulse();
    go(20, 33, 1'b1, 1'b1, "est first", 0, got, want);
    chk("est first forced zero", got, 0);
    go(0, 0, 1'b1, 1'b1, "est hold0 a", 0, got, want);
    go(0, 0, 1'b1, 1'b1, "est hold0 b", 0, got, want);
    for (int v = 0; v <= 40; v += 2) go(v, 0, 1'b1, 1'b1, $sformatf("est up %0d", v), 0, got, want);
    for (int v = 38; v >= 0; v -= 2) go(v, 0, 1'b0, 1'b1, $sformatf("est dn %0d", v), 0, got, want);
    t = 0;
    for (int n = 0; n < 100; n++) begin
      t += int'($urandom_range(0, 10)) - 5;
      if (t > 127) t = 127;
      if (t < -128) t = -128;
      go(t, int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)), 1'b1,
         $sformatf("est walk%0d", n), 0, got, want);
    end
    go(-128, 0, 1'b1, 1'b1, "est sat lo", 0, got, want);
    go(127, 0, 1'b1, 1'b1, "est sat +255", 0, got, want);
    go(-128, 0, 1'b1, 1'b1, "est sat -255", 0, got, want);
    go(10, 0, 1'b1, 1'b1, "est init mid-run", 2, got, want);
    go(12, 0, 1'b1, 1'b1, "est after mid init", 0, got, want);
    chk("est after mid init forced zero", got, 0);

    go(-64, -60, 1'b0, 1'b0, "pre-reset", 0, got, want);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    t_in = -8'sd64;
    dt_in = -8'sd60;
    reg_mode = 1'b0;
    dt_mode = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid-run reset valid", int'(valid), 0);
    chk("mid-run reset G_out", int'(g_out), 0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (valid) n_extra++;
    end
    chk("mid-run reset no valid", n_extra, 0);
    m_prev = 0;
    m_first = 1'b1;
    go(30, 5, 1'b1, 1'b1, "post-reset est first", 0, got, want);
    go(34, 5, 1'b1, 1'b1, "post-reset est next", 0, got, want);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
